// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte sources, the round-robin arbiter and the UART serializer.
// The master side drives the requests; the arbiter sits on the slave side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_data_valid;
  logic [WORD_WIDTH-1:0]         tx_data_in;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_data_valid, tx_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_data_valid, tx_data_in, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit serializer between NUM_REQ byte sources.
// The serializer has no ready, so each frame is paced by an internal hold counter.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_RATE   = 100000000,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int BAUD_DIV    = CLK_RATE / BAUD_RATE;
  localparam int HOLD_CYCLES = (WORD_WIDTH + 4) * BAUD_DIV + GAP_CYCLES + 1;
  localparam int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int ID_W        = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      hold_cnt_reg, hold_cnt_next;
  logic [ID_W-1:0]       last_grant_reg, last_grant_next;
  logic [ID_W-1:0]       grant_id_reg, grant_id_next;
  logic [WORD_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic [WORD_WIDTH-1:0] req_word [NUM_REQ];
  logic [NUM_REQ-1:0]    ready_vec;
  logic [ID_W-1:0]       winner;
  logic                  winner_found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = bus.req_data[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // base + offset with offset in 1..NUM_REQ never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!winner_found && bus.req_valid[rr_index(last_grant_reg, k)]) begin
        winner       = rr_index(last_grant_reg, k);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    last_grant_next = last_grant_reg;
    grant_id_next   = grant_id_reg;
    tx_data_next    = tx_data_reg;
    ready_vec       = '0;
    unique case (state_reg)
      IDLE: begin
        // Ready is masked during reset so no word is consumed by an edge that discards it.
        if (winner_found && !rst) begin
          ready_vec[winner] = 1'b1;
          tx_data_next      = req_word[winner];
          last_grant_next   = winner;
          grant_id_next     = winner;
          state_next        = ISSUE;
        end
      end
      ISSUE: begin
        hold_cnt_next = '0;
        state_next    = HOLD;
      end
      HOLD: begin
        if (hold_cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      grant_id_reg   <= '0;
      tx_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      last_grant_reg <= last_grant_next;
      grant_id_reg   <= grant_id_next;
      tx_data_reg    <= tx_data_next;
    end
  end

  assign bus.req_ready     = ready_vec;
  assign bus.tx_data_valid = (state_reg == ISSUE);
  assign bus.busy          = (state_reg != IDLE);
  assign bus.tx_data_in    = tx_data_reg;
  assign bus.grant_id      = grant_id_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 4-source instance checked cycle by cycle against a timing-level
// reference model, and a 3-source instance with an inter-frame gap checked for grant order and spacing.
module tb_uart_tx_arbiter;
  localparam int NA       = 4;
  localparam int NB       = 3;
  localparam int HOLD_A   = (8 + 4) * (1600 / 100) + 0 + 1;
  localparam int HOLD_B   = (8 + 4) * (1600 / 100) + 5 + 1;
  localparam int PERIOD_A = HOLD_A + 2;
  localparam int PERIOD_B = HOLD_B + 2;

  logic clock;
  logic rst_a, rst_b;

  uart_tx_arbiter_if #(.NUM_REQ(NA), .WORD_WIDTH(8)) a_if ();
  uart_tx_arbiter_if #(.NUM_REQ(NB), .WORD_WIDTH(8)) b_if ();

  uart_tx_arbiter #(
    .NUM_REQ(NA), .WORD_WIDTH(8), .BAUD_RATE(100), .CLK_RATE(1600), .GAP_CYCLES(0)
  ) dut_a (
    .clock(clock), .rst(rst_a), .bus(a_if.slave)
  );

  uart_tx_arbiter #(
    .NUM_REQ(NB), .WORD_WIDTH(8), .BAUD_RATE(100), .CLK_RATE(1600), .GAP_CYCLES(5)
  ) dut_b (
    .clock(clock), .rst(rst_b), .bus(b_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fails;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the arbiter is free from cycle free_at onward; an accept at T
  // issues at T+1 and keeps it busy until T+2+HOLD.
  int         cyc, base, free_at, issue_at, last_g, exp_gid, acc_idx, n_acc;
  logic [7:0] exp_data;
  logic [NA-1:0] v;
  logic [7:0] d [NA];
  logic [NA-1:0] mask;
  int         p_raise, p_drop, p_rst;
  bit         fixed_data;
  int         obs_idle_cyc;
  int         obs_issue_q[$];
  int         obs_gid_q[$];
  logic [NA-1:0] obs_ready;
  logic       obs_busy, prev_busy;
  bit         b_done;

  task automatic model_reset();
    free_at  = cyc + 1;
    issue_at = -1;
    last_g   = NA - 1;
    exp_data = 8'h00;
    exp_gid  = 0;
  endtask

  task automatic drive_a();
    a_if.req_valid = v;
    for (int i = 0; i < NA; i++) a_if.req_data[i*8 +: 8] = d[i];
  endtask

  task automatic step_a();
    int w;
    int j;
    drive_a();
    @(negedge clock);
    w = -1;
    if (!rst_a && cyc >= free_at) begin
      for (int k = 1; k <= NA; k++) begin
        j = (last_g + k) % NA;
        if (w < 0 && v[j]) w = j;
      end
    end
    obs_ready = a_if.req_ready;
    obs_busy  = a_if.busy;
    check_eq("a_ready", 32'(a_if.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
    check_eq("a_tx_valid", 32'(a_if.tx_data_valid), 32'(cyc == issue_at));
    check_eq("a_busy", 32'(a_if.busy), 32'(cyc < free_at));
    check_eq("a_tx_data", 32'(a_if.tx_data_in), 32'(exp_data));
    check_eq("a_grant_id", 32'(a_if.grant_id), 32'(exp_gid));
    if (a_if.tx_data_valid === 1'b1) begin
      obs_issue_q.push_back(cyc);
      obs_gid_q.push_back(int'(a_if.grant_id));
      $display("A issue  cyc=%0d grant=%0d data=%02h", cyc, a_if.grant_id, a_if.tx_data_in);
    end
    if (prev_busy === 1'b1 && a_if.busy === 1'b0) obs_idle_cyc = cyc;
    prev_busy = a_if.busy;
    @(posedge clock);
    if (rst_a) begin
      model_reset();
      acc_idx = -1;
    end else begin
      acc_idx = w;
      if (w >= 0) begin
        exp_data = d[w];
        exp_gid  = w;
        last_g   = w;
        issue_at = cyc + 1;
        free_at  = cyc + 2 + HOLD_A;
        n_acc++;
        $display("A accept cyc=%0d req=%0d data=%02h", cyc, w, d[w]);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic agents_a();
    bit dropped;
    for (int i = 0; i < NA; i++) begin
      dropped = 1'b0;
      if (acc_idx == i) begin
        v[i] = 1'b0;
      end else if (v[i] && p_drop > 0 && $urandom_range(99) < p_drop) begin
        v[i]    = 1'b0;
        dropped = 1'b1;
      end
      if (!v[i] && !dropped && mask[i] && p_raise > 0 && $urandom_range(99) < p_raise) begin
        v[i] = 1'b1;
        d[i] = fixed_data ? 8'(16 + i) : 8'($urandom_range(255));
      end
    end
    if (p_rst > 0) rst_a = ($urandom_range(999) < p_rst);
  endtask

  task automatic tick_a();
    agents_a();
    step_a();
  endtask

  task automatic run_until_issues(input int target, input int limit);
    int t0;
    t0 = cyc;
    while (obs_issue_q.size() < target && cyc - t0 < limit) tick_a();
  endtask

  task automatic run_until_idle();
    int t0;
    t0 = cyc;
    while (cyc < free_at && cyc - t0 < PERIOD_A + 10) tick_a();
  endtask

  initial begin
    int q0;
    int i0;
    n_checks = 0; n_fails = 0; n_acc = 0; acc_idx = -1;
    p_raise = 0; p_drop = 0; p_rst = 0; mask = '0; fixed_data = 1'b0;
    obs_idle_cyc = -1; prev_busy = 1'b0;
    v = '0;
    for (int i = 0; i < NA; i++) d[i] = 8'h00;
    rst_a = 1'b1;
    drive_a();
    repeat (3) @(posedge clock);
    #1;
    cyc = 0;
    model_reset();
    free_at = 0;

    // Reset held with every source requesting: no ready, all outputs at reset values.
    v = '1;
    step_a();
    step_a();
    check_eq("reset_ready", 32'(obs_ready), 32'd0);
    check_eq("reset_busy", 32'(obs_busy), 32'd0);

    // Single request from source 2 at relative cycle 10.
    rst_a = 1'b0;
    v = '0;
    base = cyc;
    while (cyc < base + 10) step_a();
    v[2] = 1'b1;
    d[2] = 8'hA5;
    step_a();
    check_eq("single_ready2", 32'(obs_ready), 32'h4);
    while (cyc < base + 215) tick_a();
    check_eq("single_issue_cyc", 32'(obs_issue_q[$] - base), 32'd11);
    check_eq("single_idle_cyc", 32'(obs_idle_cyc - base), 32'd205);
    check_eq("single_gid", 32'(obs_gid_q[$]), 32'd2);

    // All sources continuously valid after a fresh reset: 0,1,2,3,0,...
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    q0 = obs_issue_q.size();
    mask = '1; p_raise = 100; fixed_data = 1'b1;
    i0 = n_acc;
    for (int t = 0; t < 8 * PERIOD_A + 20 && n_acc - i0 < 8; t++) tick_a();
    mask = '0; p_raise = 0; v = '0;
    run_until_idle();
    check_eq("cont_issues", 32'(obs_issue_q.size() - q0), 32'd8);
    for (int k = 0; k < 8 && q0 + k < obs_issue_q.size(); k++) begin
      check_eq("cont_order", 32'(obs_gid_q[q0+k]), 32'(k % NA));
      if (k > 0) check_eq("cont_period", 32'(obs_issue_q[q0+k] - obs_issue_q[q0+k-1]), 32'(PERIOD_A));
    end

    // Wrap-around: last grant was 3, only 3 and 1 valid, so 1 wins first.
    q0 = obs_issue_q.size();
    v[3] = 1'b1; d[3] = 8'($urandom_range(255));
    v[1] = 1'b1; d[1] = 8'($urandom_range(255));
    run_until_issues(q0 + 2, 3 * PERIOD_A);
    run_until_idle();
    check_eq("wrap_issues", 32'(obs_issue_q.size() - q0), 32'd2);
    check_eq("wrap_first", 32'(obs_gid_q[q0]), 32'd1);
    check_eq("wrap_second", 32'(obs_gid_q[q0+1]), 32'd3);

    // Withdrawn request: source 1 raises and drops valid inside a hold window.
    q0 = obs_issue_q.size();
    v[0] = 1'b1; d[0] = 8'($urandom_range(255));
    run_until_issues(q0 + 1, PERIOD_A);
    i0 = obs_issue_q[$];
    while (cyc < i0 + 20) tick_a();
    v[1] = 1'b1; d[1] = 8'($urandom_range(255));
    while (cyc < i0 + 100) tick_a();
    v[1] = 1'b0;
    v[2] = 1'b1; d[2] = 8'($urandom_range(255));
    run_until_issues(q0 + 2, 2 * PERIOD_A);
    run_until_idle();
    check_eq("withdraw_issues", 32'(obs_issue_q.size() - q0), 32'd2);
    check_eq("withdraw_next_gid", 32'(obs_gid_q[q0+1]), 32'd2);

    // Reset pulse at hold count 50 with source 0 pending.
    q0 = obs_issue_q.size();
    v[3] = 1'b1; d[3] = 8'($urandom_range(255));
    run_until_issues(q0 + 1, PERIOD_A);
    i0 = obs_issue_q[$];
    while (cyc < i0 + 51) tick_a();
    v[0] = 1'b1; d[0] = 8'($urandom_range(255));
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    step_a();
    check_eq("midhold_ready0", 32'(obs_ready), 32'h1);
    check_eq("midhold_busy", 32'(obs_busy), 32'd0);
    v[0] = 1'b0;
    run_until_idle();

    // Random traffic with withdrawals and occasional resets.
    mask = '1; p_raise = 5; p_drop = 2; p_rst = 1; fixed_data = 1'b0;
    for (int t = 0; t < 6000; t++) tick_a();
    mask = '0; p_raise = 0; p_drop = 0; p_rst = 0; rst_a = 1'b0; v = '0;
    step_a();
    run_until_idle();
    check_eq("random_accepts_seen", 32'(n_acc > 20), 32'd1);

    for (int t = 0; t < 2000 && !b_done; t++) @(posedge clock);
    check_eq("b_done", 32'(b_done), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Three sources with a 5-cycle gap, all continuously valid: 0,1,2,0 spaced HOLD_B+2.
  initial begin
    int q_t[$];
    int q_g[$];
    int q_d[$];
    int bc;
    b_done = 1'b0;
    bc = 0;
    rst_b = 1'b1;
    b_if.req_valid = '0;
    b_if.req_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    rst_b = 1'b0;
    b_if.req_valid = 3'b111;
    b_if.req_data  = {8'h22, 8'h21, 8'h20};
    while (q_t.size() < 4 && bc < 5 * PERIOD_B) begin
      @(negedge clock);
      if (b_if.tx_data_valid === 1'b1) begin
        q_t.push_back(bc);
        q_g.push_back(int'(b_if.grant_id));
        q_d.push_back(int'(b_if.tx_data_in));
        $display("B issue  cyc=%0d grant=%0d data=%02h", bc, b_if.grant_id, b_if.tx_data_in);
      end
      @(posedge clock);
      #1;
      bc++;
    end
    check_eq("b_issues", 32'(q_t.size()), 32'd4);
    for (int k = 0; k < q_t.size(); k++) begin
      check_eq("b_order", 32'(q_g[k]), 32'(k % NB));
      check_eq("b_payload", 32'(q_d[k]), 32'(8'h20 + (k % NB)));
      if (k > 0) check_eq("b_period", 32'(q_t[k] - q_t[k-1]), 32'(PERIOD_B));
    end
    b_done = 1'b1;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit serializer between `NUM_REQ` independent byte sources. Each source presents words on a valid/ready handshake. The arbiter accepts one word, issues it to the serializer with a single-cycle `tx_data_valid` pulse, then holds off all sources for one full frame time before granting again. The serializer exposes no ready signal, so frame occupancy is enforced internally by a cycle counter.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WORD_WIDTH`, 8: data bits per frame; must match the serializer.
- `BAUD_RATE`, 115200: serial bit rate.
- `CLK_RATE`, 100000000: clock frequency in Hz. `BAUD_DIV = CLK_RATE / BAUD_RATE`, integer division.
- `GAP_CYCLES`, 0: extra idle clock cycles inserted between frames.
- `clock`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  bit i: requester i has a word.
- `req_data`  in  NUM_REQ*WORD_WIDTH  word of requester i in bits [i*WORD_WIDTH +: WORD_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i high means requester i's word is taken this cycle.
- `tx_data_valid`  out  1  single-cycle issue strobe to the serializer.
- `tx_data_in`  out  WORD_WIDTH  word to the serializer; stable from the issue cycle until the next accept.
- `grant_id`  out  $clog2(NUM_REQ)  index of the most recently accepted requester.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Serializer contract.** After seeing `tx_data_valid` while idle, the serializer is occupied for `(WORD_WIDTH+4)*BAUD_DIV` cycles: start, data, parity, stop and wait bits.
- **Derived constant.** `HOLD_CYCLES = (WORD_WIDTH+4)*BAUD_DIV + GAP_CYCLES + 1`.
- **State IDLE.**
  - The winner is the first asserted `req_valid` searched from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - `req_ready[winner]` is driven combinationally in the same cycle. A transfer occurs when valid and ready are both high.
  - On transfer: latch the winner's word into `tx_data_in`, set `last_grant` and `grant_id` to the winner, go to ISSUE.
  - With no valid asserted: stay in IDLE with `req_ready` = 0.
- **State ISSUE.** `tx_data_valid` = 1 for exactly this one cycle. Clear the hold counter and go to HOLD.
- **State HOLD.**
  - The counter increments each cycle. When it reaches `HOLD_CYCLES-1`, go to IDLE.
  - `req_ready` = 0 throughout HOLD.
- **Requester rules.**
  - A requester holds valid and data stable until it sees ready.
  - Dropping valid before ready is legal and produces no transfer.
  - A requester granted in the last round gets lowest priority in the next round.
- **Width rules.**
  - The hold counter is `$clog2(HOLD_CYCLES)` bits wide.
  - The pointer increment wraps `NUM_REQ-1` → 0, including for non-power-of-2 `NUM_REQ`.
- **Reset values.**
  - State IDLE; `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready` = 0 while `rst` is high.
  - `tx_data_valid` = 0, `tx_data_in` = 0, `grant_id` = 0, `busy` = 0.
- **Reset mid-operation.**
  - Reset during ISSUE or HOLD returns to IDLE on the next edge and discards any in-flight hold.
  - The serializer is reset by the same `rst`, so no partial frame survives.

## Timing
- **Accept to issue.** With an accept in cycle T: `tx_data_valid` is high in T+1, and `busy` is high from T+1.
- **Hold window.** HOLD spans T+2 .. T+1+HOLD_CYCLES. IDLE resumes, and the earliest next accept occurs, at T+2+HOLD_CYCLES.
- **Back-to-back period.** Issues are spaced exactly `HOLD_CYCLES+2` cycles apart.
- **Simultaneous requests.** Only the round-robin winner sees ready; the others wait with no data loss.
- **Late request.** A request that arrives during HOLD is not accepted until IDLE.

## Test plan
Common setup: `CLK_RATE=1600`, `BAUD_RATE=100` (`BAUD_DIV=16`), `WORD_WIDTH=8`, `GAP_CYCLES=0`, so `HOLD_CYCLES=193`.

- **Single request.** Requester 2 asserts valid with 0xA5 at cycle 10 → `req_ready[2]` high in cycle 10, `tx_data_valid` high only in cycle 11 with `tx_data_in`=0xA5, `busy` high for cycles 11..204, IDLE at cycle 205.
- **All requesters continuous.** All four hold valid with data 0x10, 0x11, 0x12, 0x13 → grant order 0,1,2,3,0, `tx_data_valid` pulses exactly 195 cycles apart, payloads match the granted index.
- **Wrap-around.** After `last_grant`=3, only requesters 3 and 1 are valid → requester 1 is granted first, then 3.
- **Withdrawn request.** Requester 1 raises valid during HOLD and drops it before IDLE → no ready and no issue for requester 1; the next valid requester is served normally.
- **Reset mid-hold.** Assert `rst` for 1 cycle at hold count 50 → next cycle IDLE, `busy`=0, `tx_data_valid`=0; a pending requester 0 is accepted in the first cycle after reset deasserts.
- **Gap and non-power-of-2.** `GAP_CYCLES=5`, `NUM_REQ=3`, all valid → grants 0,1,2,0 spaced 200 cycles, pointer wraps 2→0.
